// File: rtl/dev_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dev_bus_arbiter_pkg : shared state encodings and constants for the bus arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dev_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam int c_M0 = 0;
  localparam int c_M1 = 1;

  localparam int c_PRIO_RR    = 0;
  localparam int c_PRIO_FIXED = 1;

endpackage

`default_nettype wire

// File: rtl/dev_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// dev_bus_arbiter_if : two-master req/ack handshake plus bridge-side bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dev_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wd;
  logic              m0_we;
  logic [DATA_W-1:0] m0_rd;
  logic              m0_ack;
  logic              m0_stall;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wd;
  logic              m1_we;
  logic [DATA_W-1:0] m1_rd;
  logic              m1_ack;

  logic [ADDR_W-1:0] pr_addr;
  logic [DATA_W-1:0] pr_wd;
  logic              pr_we;
  logic [DATA_W-1:0] pr_rd;
  logic [1:0]        gnt;

  // Arbiter side
  modport slave (
    input  m0_req, m0_addr, m0_wd, m0_we,
    input  m1_req, m1_addr, m1_wd, m1_we,
    input  pr_rd,
    output m0_rd, m0_ack, m0_stall,
    output m1_rd, m1_ack,
    output pr_addr, pr_wd, pr_we, gnt
  );

  // Masters plus bridge side
  modport master (
    output m0_req, m0_addr, m0_wd, m0_we,
    output m1_req, m1_addr, m1_wd, m1_we,
    output pr_rd,
    input  m0_rd, m0_ack, m0_stall,
    input  m1_rd, m1_ack,
    input  pr_addr, pr_wd, pr_we, gnt
  );

endinterface

`default_nettype wire

// File: rtl/dev_arb_pick.sv
// ---------------------------------------------------------------------------
// dev_arb_pick : combinational one-hot winner select, round-robin or M0 priority
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dev_arb_pick
  import dev_bus_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = c_PRIO_RR
) (
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  output logic [1:0] o_win
);

  // i_last_gnt=1 means M1 owned the bus last, so M0 takes a round-robin tie
  always_comb begin
    o_win = 2'b00;
    case (i_req)
      2'b01:   o_win = 2'b01;
      2'b10:   o_win = 2'b10;
      2'b11:   o_win = ((PRIO_MODE == c_PRIO_FIXED) || i_last_gnt) ? 2'b01 : 2'b10;
      default: o_win = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dev_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dev_bus_arbiter : shares the processor device bus between CPU and DMA masters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dev_bus_arbiter
  import dev_bus_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = c_PRIO_RR,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  dev_bus_arbiter_if.slave       bus
);

  state_t            r_state;
  logic [1:0]        r_gnt;
  logic [1:0]        r_ack;
  logic              r_last_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wd;
  logic              r_we;
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] r_rd1;
  logic [1:0]        w_win;

  dev_arb_pick #(
    .PRIO_MODE (PRIO_MODE)
  ) u_pick (
    .i_req      ({bus.m1_req, bus.m0_req}),
    .i_last_gnt (r_last_gnt),
    .o_win      (w_win)
  );

  // r_addr/r_wd/r_we double as the bridge outputs: non-zero only during ACCESS
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_gnt      <= 2'b00;
      r_ack      <= 2'b00;
      r_last_gnt <= 1'b1;
      r_addr     <= '0;
      r_wd       <= '0;
      r_we       <= 1'b0;
      r_rd0      <= '0;
      r_rd1      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win != 2'b00) begin
            r_gnt   <= w_win;
            r_addr  <= w_win[c_M1] ? bus.m1_addr : bus.m0_addr;
            r_wd    <= w_win[c_M1] ? bus.m1_wd   : bus.m0_wd;
            r_we    <= w_win[c_M1] ? bus.m1_we   : bus.m0_we;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_gnt[c_M1]) begin
            r_rd1 <= bus.pr_rd;
          end else begin
            r_rd0 <= bus.pr_rd;
          end
          r_ack      <= r_gnt;
          r_last_gnt <= r_gnt[c_M1];
          r_addr     <= '0;
          r_wd       <= '0;
          r_we       <= 1'b0;
          r_state    <= ST_ACK;
        end
        ST_ACK: begin
          r_ack   <= 2'b00;
          r_gnt   <= 2'b00;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ack   <= 2'b00;
          r_gnt   <= 2'b00;
          r_addr  <= '0;
          r_wd    <= '0;
          r_we    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pr_addr  = r_addr;
  assign bus.pr_wd    = r_wd;
  assign bus.pr_we    = r_we;
  assign bus.gnt      = r_gnt;
  assign bus.m0_rd    = r_rd0;
  assign bus.m1_rd    = r_rd1;
  assign bus.m0_ack   = r_ack[c_M0];
  assign bus.m1_ack   = r_ack[c_M1];
  assign bus.m0_stall = bus.m0_req & ~r_ack[c_M0];

endmodule

`default_nettype wire

// File: tb/tb_dev_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dev_bus_arbiter : round-robin and priority arbiters against a timeline model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dev_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dev_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  dev_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  dev_bus_arbiter #(.PRIO_MODE(0), .ADDR_W(32), .DATA_W(32)) u_dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  dev_bus_arbiter #(.PRIO_MODE(1), .ADDR_W(32), .DATA_W(32)) u_dut_prio (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // index [i][m]: i=0 round-robin instance, i=1 priority instance; m = master
  logic        t_req  [2][2];
  logic [31:0] t_addr [2][2];
  logic [31:0] t_wd   [2][2];
  logic        t_we   [2][2];
  logic [31:0] t_prrd [2];

  logic [31:0] ob_rd  [2][2];
  logic        ob_ack [2][2];
  logic        ob_stall [2];
  logic [31:0] ob_addr [2];
  logic [31:0] ob_wd   [2];
  logic        ob_we   [2];
  logic [1:0]  ob_gnt  [2];

  assign bus0.m0_req = t_req[0][0];  assign bus0.m1_req = t_req[0][1];
  assign bus0.m0_addr = t_addr[0][0]; assign bus0.m1_addr = t_addr[0][1];
  assign bus0.m0_wd = t_wd[0][0];    assign bus0.m1_wd = t_wd[0][1];
  assign bus0.m0_we = t_we[0][0];    assign bus0.m1_we = t_we[0][1];
  assign bus0.pr_rd = t_prrd[0];
  assign bus1.m0_req = t_req[1][0];  assign bus1.m1_req = t_req[1][1];
  assign bus1.m0_addr = t_addr[1][0]; assign bus1.m1_addr = t_addr[1][1];
  assign bus1.m0_wd = t_wd[1][0];    assign bus1.m1_wd = t_wd[1][1];
  assign bus1.m0_we = t_we[1][0];    assign bus1.m1_we = t_we[1][1];
  assign bus1.pr_rd = t_prrd[1];

  assign ob_rd[0][0] = bus0.m0_rd;   assign ob_rd[0][1] = bus0.m1_rd;
  assign ob_ack[0][0] = bus0.m0_ack; assign ob_ack[0][1] = bus0.m1_ack;
  assign ob_stall[0] = bus0.m0_stall;
  assign ob_addr[0] = bus0.pr_addr;  assign ob_wd[0] = bus0.pr_wd;
  assign ob_we[0] = bus0.pr_we;      assign ob_gnt[0] = bus0.gnt;
  assign ob_rd[1][0] = bus1.m0_rd;   assign ob_rd[1][1] = bus1.m1_rd;
  assign ob_ack[1][0] = bus1.m0_ack; assign ob_ack[1][1] = bus1.m1_ack;
  assign ob_stall[1] = bus1.m0_stall;
  assign ob_addr[1] = bus1.pr_addr;  assign ob_wd[1] = bus1.pr_wd;
  assign ob_we[1] = bus1.pr_we;      assign ob_gnt[1] = bus1.gnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Transaction timeline: granted at edge g, bus active in cycle g, ack in cycle g+1,
  // next grant possible at edge g+3.
  int          g    [2];
  int          own  [2];
  int          last [2];
  logic [31:0] la   [2];
  logic [31:0] lwd  [2];
  logic        lwe  [2];
  logic [31:0] mrd  [2][2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input int i, input int e);
    int w;
    if (!reset) begin
      g[i] = -100; last[i] = 1; mrd[i][0] = '0; mrd[i][1] = '0;
      return;
    end
    if (e == g[i] + 1) begin
      mrd[i][own[i]] = t_prrd[i];
      last[i] = own[i];
    end
    if (e >= g[i] + 3 && (t_req[i][0] || t_req[i][1])) begin
      if (t_req[i][0] && t_req[i][1]) w = (i == 1) ? 0 : 1 - last[i];
      else                            w = t_req[i][1] ? 1 : 0;
      own[i] = w; g[i] = e;
      la[i] = t_addr[i][w]; lwd[i] = t_wd[i][w]; lwe[i] = t_we[i][w];
    end
  endtask

  function automatic logic exp_ack(input int i, input int m);
    return (cyc == g[i] + 1) && (own[i] == m);
  endfunction

  task automatic check_cycle(input int i);
    logic  acc, ak0, ak1;
    string p;
    p   = (i == 0) ? "rr" : "prio";
    acc = (cyc == g[i]);
    ak0 = exp_ack(i, 0);
    ak1 = exp_ack(i, 1);
    chk({p, " gnt"}, ob_gnt[i], (acc || ak0 || ak1) ? ((own[i] == 1) ? 2'b10 : 2'b01) : 2'b00);
    chk({p, " pr_we"}, ob_we[i], acc ? lwe[i] : 1'b0);
    chk({p, " pr_addr"}, ob_addr[i], acc ? la[i] : 32'h0);
    chk({p, " pr_wd"}, ob_wd[i], acc ? lwd[i] : 32'h0);
    chk({p, " m0_ack"}, ob_ack[i][0], ak0);
    chk({p, " m1_ack"}, ob_ack[i][1], ak1);
    chk({p, " m0_rd"}, ob_rd[i][0], mrd[i][0]);
    chk({p, " m1_rd"}, ob_rd[i][1], mrd[i][1]);
    chk({p, " m0_stall"}, ob_stall[i], t_req[i][0] & ~ak0);
  endtask

  task automatic step();
    int e;
    e = cyc + 1;
    model_edge(0, e);
    model_edge(1, e);
    @(posedge clk);
    cyc = e;
    @(negedge clk);
    check_cycle(0);
    check_cycle(1);
  endtask

  task automatic setm(input int m, input logic req, input logic [31:0] a,
                      input logic [31:0] d, input logic we);
    for (int i = 0; i < 2; i++) begin
      t_req[i][m] = req; t_addr[i][m] = a; t_wd[i][m] = d; t_we[i][m] = we;
    end
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 2; i++) begin
      for (int m = 0; m < 2; m++) begin
        t_req[i][m] = 1'b0; t_addr[i][m] = '0; t_wd[i][m] = '0; t_we[i][m] = 1'b0;
        mrd[i][m] = '0;
      end
      t_prrd[i] = '0; g[i] = -100; own[i] = 0; last[i] = 1;
      la[i] = '0; lwd[i] = '0; lwe[i] = 1'b0;
    end

    reset = 1'b0;
    step();
    step();
    chk("reset gnt", ob_gnt[0], 2'b00);
    chk("reset ack", {ob_ack[0][0], ob_ack[0][1]}, 2'b00);
    chk("reset rd", ob_rd[0][0], 32'h0);
    reset = 1'b1;

    // M0 write
    setm(0, 1'b1, 32'h0000_7F04, 32'h0000_00FF, 1'b1);
    step();
    chk("m0wr pr_we", ob_we[0], 1'b1);
    chk("m0wr pr_addr", ob_addr[0], 32'h0000_7F04);
    chk("m0wr pr_wd", ob_wd[0], 32'h0000_00FF);
    chk("m0wr stall", ob_stall[0], 1'b1);
    step();
    chk("m0wr ack", ob_ack[0][0], 1'b1);
    chk("m0wr pr_we off", ob_we[0], 1'b0);
    chk("m0wr stall off", ob_stall[0], 1'b0);
    setm(0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();

    // M1 read
    t_prrd[0] = 32'h1234_5678; t_prrd[1] = 32'h1234_5678;
    setm(1, 1'b1, 32'h0000_7F18, 32'h0, 1'b0);
    step();
    step();
    chk("m1rd rd", ob_rd[0][1], 32'h1234_5678);
    chk("m1rd ack", ob_ack[0][1], 1'b1);
    chk("m1rd m0 ack", ob_ack[0][0], 1'b0);
    setm(1, 1'b0, 32'h0, 32'h0, 1'b0);
    step();

    // Sustained simultaneous requests from reset
    reset = 1'b0;
    step();
    reset = 1'b1;
    setm(0, 1'b1, 32'h0000_7F00, 32'h11, 1'b1);
    setm(1, 1'b1, 32'h0000_7F08, 32'h22, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1 || k == 4 || k == 7 || k == 10) begin
        chk("rr tie gnt", ob_gnt[0], (k == 4 || k == 10) ? 2'b10 : 2'b01);
        chk("prio tie gnt", ob_gnt[1], 2'b01);
      end
      if (k == 11) setm(0, 1'b0, 32'h0, 32'h0, 1'b0);
      if (k == 13) begin
        chk("rr m1 after drop", ob_gnt[0], 2'b10);
        chk("prio m1 after drop", ob_gnt[1], 2'b10);
      end
    end
    setm(1, 1'b0, 32'h0, 32'h0, 1'b0);
    step();

    // Reset during ACCESS of an M1 write
    setm(1, 1'b1, 32'h0000_7F20, 32'h0000_00AA, 1'b1);
    step();
    chk("rst-abort pre we", ob_we[0], 1'b1);
    reset = 1'b0;
    step();
    chk("rst-abort we", ob_we[0], 1'b0);
    chk("rst-abort gnt", ob_gnt[0], 2'b00);
    chk("rst-abort ack", ob_ack[0][1], 1'b0);
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (ob_we[0] === 1'b1) pulses++;
      if (exp_ack(0, 1)) setm(1, 1'b0, 32'h0, 32'h0, 1'b0);
    end
    chk("rst-abort single write", pulses, 1);

    // Address change while the transaction is on the bus
    setm(0, 1'b1, 32'h0000_7F00, 32'h5, 1'b0);
    step();
    setm(0, 1'b1, 32'h0000_7F10, 32'h5, 1'b0);
    #1;
    chk("latch pr_addr rr", ob_addr[0], 32'h0000_7F00);
    chk("latch pr_addr prio", ob_addr[1], 32'h0000_7F00);
    step();
    setm(0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();

    // Randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < 2; i++) begin
        t_prrd[i] = $urandom;
        for (int m = 0; m < 2; m++) begin
          if (exp_ack(i, m)) begin
            t_req[i][m] = ($urandom_range(0, 1) == 1);
            t_addr[i][m] = $urandom; t_wd[i][m] = $urandom; t_we[i][m] = $urandom_range(0, 1);
          end else if (!t_req[i][m]) begin
            t_req[i][m] = ($urandom_range(0, 2) == 0);
            t_addr[i][m] = $urandom; t_wd[i][m] = $urandom; t_we[i][m] = $urandom_range(0, 1);
          end
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
